// File: rtl/pwm_dac.sv
// PWM audio DAC front-end: a small valid/ready sample FIFO feeds a duty register that is
// reloaded once per 2^W-cycle PWM period, producing a single registered PWM bit.
module pwm_dac #(
  parameter int CODE_WIDTH = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_CODE  = 2 ** (CODE_WIDTH - 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CODE_WIDTH-1:0]         sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          pwm_out,
  output logic                          period_start,
  output logic                          underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CODE_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CODE_WIDTH-1:0] IDLE_DUTY = CODE_WIDTH'(IDLE_CODE);
  localparam logic [PTR_W:0]        DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);

  logic [CODE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [CODE_WIDTH-1:0] cnt;
  logic [CODE_WIDTH-1:0] duty;
  logic                  push;
  logic                  pop;
  logic                  boundary;
  logic                  fifo_empty;

  // Ready depends only on the stored count, so a full FIFO refuses a push even while popping.
  assign sample_ready = (count < DEPTH);
  assign fifo_empty   = (count == '0);
  assign fifo_count   = count;
  assign push         = sample_valid && sample_ready;
  assign boundary     = enable && (cnt == CNT_MAX);
  assign pop          = boundary && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Parking cnt at all-ones while disabled makes the first enabled cycle a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= CNT_MAX;
      duty         <= IDLE_DUTY;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      underflow    <= 1'b0;
    end else if (!enable) begin
      cnt          <= CNT_MAX;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      cnt          <= cnt + 1'b1;
      pwm_out      <= (cnt < duty);
      period_start <= boundary;
      underflow    <= boundary && fifo_empty;
      if (pop) begin
        duty <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac (W=4, depth 4): directed scenarios plus a random phase,
// all compared against a queue-based period model.
module tb_pwm_dac;

  localparam int W = 4;
  localparam int D = 4;
  localparam int P = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic [2:0]   fifo_count;
  logic         pwm_out;
  logic         period_start;
  logic         underflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: queue of pending codes, current duty, and position within the period
  // counted in enabled cycles since the counter was last parked.
  int m_q[$];
  int m_duty;
  int m_pos;
  bit m_pwm;
  bit m_ps;
  bit m_uf;

  pwm_dac #(.CODE_WIDTH(W), .FIFO_DEPTH(D), .IDLE_CODE(P / 2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .fifo_count(fifo_count),
    .pwm_out(pwm_out),
    .period_start(period_start),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput($sformatf("%s@%0d/pwm_out", tag, cyc), 32'(pwm_out), 32'(m_pwm));
    checkOutput($sformatf("%s@%0d/period_start", tag, cyc), 32'(period_start), 32'(m_ps));
    checkOutput($sformatf("%s@%0d/underflow", tag, cyc), 32'(underflow), 32'(m_uf));
    checkOutput($sformatf("%s@%0d/fifo_count", tag, cyc), 32'(fifo_count), 32'(m_q.size()));
    checkOutput($sformatf("%s@%0d/sample_ready", tag, cyc), 32'(sample_ready), 32'(m_q.size() < D));
  endtask

  task automatic modelReset();
    m_q.delete();
    m_duty = P / 2;
    m_pos  = 0;
    m_pwm  = 1'b0;
    m_ps   = 1'b0;
    m_uf   = 1'b0;
  endtask

  // Asynchronous reset asserted away from any clock edge; outputs must clear at once.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, "/rst_pwm_out"}, 32'(pwm_out), 32'd0);
    checkOutput({tag, "/rst_fifo_count"}, 32'(fifo_count), 32'd0);
    checkOutput({tag, "/rst_period_start"}, 32'(period_start), 32'd0);
    checkOutput({tag, "/rst_underflow"}, 32'(underflow), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput({tag, "/rel_sample_ready"}, 32'(sample_ready), 32'd1);
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic applyStimulus(input string tag, input bit en, input bit sv, input int code,
                               output bit pushed);
    int phase;
    enable       = en;
    sample_valid = sv;
    sample_in    = code[W-1:0];
    pushed       = sv && (m_q.size() < D);
    if (en) begin
      phase = m_pos % P;
      m_pwm = (phase != 0) && ((phase - 1) < m_duty);
      m_ps  = (phase == 0);
      m_uf  = (phase == 0) && (m_q.size() == 0);
      if (phase == 0 && m_q.size() > 0) m_duty = m_q.pop_front();
      m_pos = (m_pos + 1) % P;
    end else begin
      m_pos = 0;
      m_pwm = 1'b0;
      m_ps  = 1'b0;
      m_uf  = 1'b0;
    end
    if (pushed) m_q.push_back(code);
    @(posedge clk);
    #1;
    cyc++;
    checkAll(tag);
  endtask

  task automatic runCycles(input string tag, input bit en, input int n);
    bit pushed;
    for (int i = 0; i < n; i++) applyStimulus(tag, en, 1'b0, 0, pushed);
  endtask

  task automatic pushCode(input string tag, input bit en, input int code);
    bit pushed;
    applyStimulus(tag, en, 1'b1, code, pushed);
  endtask

  initial begin
    bit pushed;
    bit accepted;
    int high_cnt;
    #2;
    doReset("init");

    // Code 4: one load at the first enabled cycle, then 4 high cycles per period.
    pushCode("t2_push", 1'b0, 4);
    runCycles("t2_run", 1'b1, 40);
    high_cnt = 0;
    for (int i = 0; i < P; i++) begin
      applyStimulus("t2_period", 1'b1, 1'b0, 0, pushed);
      high_cnt += int'(pwm_out);
    end
    checkOutput("t2_high_cycles_per_period", 32'(high_cnt), 32'd4);
    for (int i = 0; i < P && !m_pwm; i++) applyStimulus("t1_seek", 1'b1, 1'b0, 0, pushed);
    #2;
    doReset("t1_midrun");

    // Extremes: code 0 never high, code 15 high all but one cycle.
    pushCode("t3_push0", 1'b0, 0);
    pushCode("t3_push15", 1'b0, 15);
    runCycles("t3_run", 1'b1, 48);

    // Overfill while parked: the fifth sample waits for the first pop.
    runCycles("t4_park", 1'b0, 2);
    for (int i = 0; i < 4; i++) pushCode("t4_fill", 1'b0, 3 * i + 2);
    applyStimulus("t4_fifth_parked", 1'b0, 1'b1, 13, pushed);
    checkOutput("t4_ready_when_full", 32'(sample_ready), 32'd0);
    accepted = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      applyStimulus("t4_hold", 1'b1, 1'b1, 13, pushed);
      accepted = pushed;
    end
    checkOutput("t4_fifth_accepted", 32'(accepted), 32'd1);
    runCycles("t4_drain", 1'b1, 6 * P);

    // Single code then starvation: underflow every period, duty retained.
    doReset("t5_reset");
    pushCode("t5_push9", 1'b0, 9);
    runCycles("t5_run", 1'b1, 4 * P);

    // Push and pop in the same boundary cycle at count 2.
    runCycles("t6_park", 1'b0, 1);
    pushCode("t6_pushA", 1'b0, 6);
    pushCode("t6_pushB", 1'b0, 11);
    applyStimulus("t6_boundary", 1'b1, 1'b1, 1, pushed);
    checkOutput("t6_count_after_push_pop", 32'(fifo_count), 32'd2);
    runCycles("t6_run", 1'b1, 4 * P);

    // Random traffic with occasional disables and one asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        #2;
        doReset("rand_reset");
      end
      applyStimulus("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, P - 1)), pushed);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
